// File: rtl/pht_scheduler.sv
// ============================================================================
// pht_scheduler
// ----------------------------------------------------------------------------
// Pattern history table of 2^IDX_W two-bit saturating counters. The table has
// a single access slot. Predictions and queued training updates share it.
//
// Each cycle the slot is granted in this order:
//   1. Drain the update queue when it is full, so it never deadlocks.
//   2. Serve a prediction request.
//   3. Drain the update queue when it is non-empty.
//   4. Idle.
//
// Resolved branches are buffered in a small FIFO. Each drain pops one entry
// and applies it to the table as a read-modify-write in the same cycle.
// A prediction reads the table in the acceptance cycle and returns its result
// one cycle later. Queued updates are not forwarded to predictions, so a
// prediction sees only updates that have already been drained.
//
// Parameters
//   IDX_W     table index width; the table holds 2^IDX_W counters
//   UQ_DEPTH  update-queue depth; must be a power of two, >= 2
//
// Ports
//   clk         clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   pred_req    prediction request
//   pred_idx    counter index to predict from
//   pred_ready  a prediction can be accepted this cycle (queue not full)
//   pred_valid  pred_taken carries a result this cycle
//   pred_taken  predicted direction; holds its value while pred_valid = 0
//   upd_valid   a resolved branch is offered
//   upd_idx     counter index to train
//   upd_taken   resolved direction
//   upd_ready   the update queue is not full
//   q_count     number of queued updates
//   stat_pred   accepted predictions (saturating at 16'hFFFF)
//   stat_stall  cycles with pred_req && !pred_ready (saturating at 16'hFFFF)
//
// Configuration
//   PHT_STATS_EN  When defined, the two statistics counters are built.
//                 Otherwise stat_pred and stat_stall are tied to 0.
// ============================================================================
module pht_scheduler #(
   parameter int IDX_W    = 4,
   parameter int UQ_DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   // prediction port
   input  logic                       pred_req,
   input  logic [IDX_W-1:0]           pred_idx,
   output logic                       pred_ready,
   output logic                       pred_valid,
   output logic                       pred_taken,
   // training port
   input  logic                       upd_valid,
   input  logic [IDX_W-1:0]           upd_idx,
   input  logic                       upd_taken,
   output logic                       upd_ready,
   output logic [$clog2(UQ_DEPTH):0]  q_count,
   // statistics
   output logic [15:0]                stat_pred,
   output logic [15:0]                stat_stall
);

   localparam int TBL_SIZE = 1 << IDX_W;
   localparam int PTR_W    = $clog2(UQ_DEPTH);
   localparam int CNT_W    = PTR_W + 1;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(UQ_DEPTH);

   // Owner of the table access slot in the current cycle.
   typedef enum logic [1:0] {
      SLOT_IDLE,
      SLOT_PRED,
      SLOT_DRAIN
   } slot_t;

   // -------------------------------------------------------------------------
   // Storage
   // -------------------------------------------------------------------------
   logic [TBL_SIZE-1:0][1:0] pht;

   logic [IDX_W-1:0]         uq_idx   [UQ_DEPTH];
   logic                     uq_taken [UQ_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;

   // -------------------------------------------------------------------------
   // Slot arbitration
   // -------------------------------------------------------------------------
   logic  q_full;
   logic  q_empty;
   slot_t slot;
   logic  pred_accept;
   logic  drain;
   logic  enq;

   assign q_full  = (q_count == FULL_CNT);
   assign q_empty = (q_count == '0);

   // A full queue must drain even when a prediction is waiting. Otherwise a
   // steady request stream could block training indefinitely.
   // NOTE: every variable written in always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      slot = SLOT_IDLE;
      if (q_full)
         slot = SLOT_DRAIN;
      else if (pred_req)
         slot = SLOT_PRED;
      else if (!q_empty)
         slot = SLOT_DRAIN;
   end

   assign pred_ready  = !q_full;
   assign upd_ready   = !q_full;
   assign pred_accept = (slot == SLOT_PRED);
   assign drain       = (slot == SLOT_DRAIN);
   assign enq         = upd_valid && upd_ready;

   // -------------------------------------------------------------------------
   // Saturating counter update for the queue head
   // -------------------------------------------------------------------------
   logic [IDX_W-1:0] head_idx;
   logic             head_taken;
   logic [1:0]       head_ctr;
   logic [1:0]       ctr_next;

   assign head_idx   = uq_idx[rd_ptr];
   assign head_taken = uq_taken[rd_ptr];
   assign head_ctr   = pht[head_idx];

   always_comb begin
      ctr_next = head_ctr;
      if (head_taken && head_ctr != 2'b11)
         ctr_next = head_ctr + 2'd1;
      else if (!head_taken && head_ctr != 2'b00)
         ctr_next = head_ctr - 2'd1;
   end

   // -------------------------------------------------------------------------
   // Counter table
   // -------------------------------------------------------------------------
   // NOTE: the table must read strongly-taken while rst_n is low, so it is
   // built from resettable flops. The queue payload below is deliberately
   // left unreset, because the pointers and q_count alone define which
   // entries are live.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         pht <= {TBL_SIZE{2'b11}};
      else if (drain)
         pht[head_idx] <= ctr_next;
   end

   // -------------------------------------------------------------------------
   // Update queue
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (enq) begin
         uq_idx[wr_ptr]   <= upd_idx;
         uq_taken[wr_ptr] <= upd_taken;
      end
   end

   // Pointers wrap naturally because UQ_DEPTH is a power of two. A
   // simultaneous enqueue and drain leaves q_count unchanged.
   // NOTE: sequential state uses non-blocking assignments, so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_count <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (drain)
            rd_ptr <= rd_ptr + PTR_W'(1);
         q_count <= q_count + CNT_W'(enq) - CNT_W'(drain);
      end
   end

   // -------------------------------------------------------------------------
   // Prediction response
   // -------------------------------------------------------------------------
   // The table is read in the acceptance cycle and the result is registered.
   // pred_taken keeps its value between predictions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
      end else begin
         pred_valid <= pred_accept;
         if (pred_accept)
            pred_taken <= pht[pred_idx][1];
      end
   end

   // -------------------------------------------------------------------------
   // Statistics
   // -------------------------------------------------------------------------
`ifdef PHT_STATS_EN
   logic stall;

   assign stall = pred_req && !pred_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_pred  <= '0;
         stat_stall <= '0;
      end else begin
         if (pred_accept && stat_pred != 16'hFFFF)
            stat_pred <= stat_pred + 16'd1;
         if (stall && stat_stall != 16'hFFFF)
            stat_stall <= stat_stall + 16'd1;
      end
   end
`else
   assign stat_pred  = 16'd0;
   assign stat_stall = 16'd0;
`endif

endmodule

// File: tb/tb_pht_scheduler.sv
// ============================================================================
// tb_pht_scheduler
// ----------------------------------------------------------------------------
// Self-checking bench for pht_scheduler. A behavioural model holds the
// counters as integers and the update queue as an SV queue. It follows the
// slot-priority rule directly. Directed sequences cover the reset, drain,
// stall and saturation scenarios. Randomized traffic then runs against the
// model, with one reset asserted mid-run. Define PHT_STATS_EN for both the
// bench and the RTL to check the statistics counters.
// ============================================================================
module tb_pht_scheduler;

   localparam int IDX_W    = 4;
   localparam int UQ_DEPTH = 4;
   localparam int TBL_SIZE = 1 << IDX_W;

   logic                       clk;
   logic                       rst_n;
   logic                       pred_req;
   logic [IDX_W-1:0]           pred_idx;
   logic                       pred_ready;
   logic                       pred_valid;
   logic                       pred_taken;
   logic                       upd_valid;
   logic [IDX_W-1:0]           upd_idx;
   logic                       upd_taken;
   logic                       upd_ready;
   logic [$clog2(UQ_DEPTH):0]  q_count;
   logic [15:0]                stat_pred;
   logic [15:0]                stat_stall;

   pht_scheduler #(
      .IDX_W    (IDX_W),
      .UQ_DEPTH (UQ_DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pred_req   (pred_req),
      .pred_idx   (pred_idx),
      .pred_ready (pred_ready),
      .pred_valid (pred_valid),
      .pred_taken (pred_taken),
      .upd_valid  (upd_valid),
      .upd_idx    (upd_idx),
      .upd_taken  (upd_taken),
      .upd_ready  (upd_ready),
      .q_count    (q_count),
      .stat_pred  (stat_pred),
      .stat_stall (stat_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // -------------------------------------------------------------------------
   // Checking
   // -------------------------------------------------------------------------
   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // -------------------------------------------------------------------------
   // Reference model
   // -------------------------------------------------------------------------
   typedef struct {
      int idx;
      bit taken;
   } upd_t;

   int   m_cnt [TBL_SIZE];
   upd_t m_q   [$];
   bit   m_valid;
   bit   m_taken;
   int   m_spred;
   int   m_sstall;

`ifdef PHT_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   function automatic void model_reset();
      foreach (m_cnt[i]) m_cnt[i] = 3;
      m_q.delete();
      m_valid  = 1'b0;
      m_taken  = 1'b0;
      m_spred  = 0;
      m_sstall = 0;
   endfunction

   task automatic check_state();
      check("q_count",    q_count,    m_q.size());
      check("pred_valid", pred_valid, m_valid);
      check("pred_taken", pred_taken, m_taken);
      check("stat_pred",  stat_pred,  STATS ? m_spred  : 0);
      check("stat_stall", stat_stall, STATS ? m_sstall : 0);
   endtask

   // Drives one cycle of inputs from posedge+1, checks the ready outputs,
   // advances the model across the edge, and checks the registered state
   // at the following posedge+1.
   task automatic cycle(input bit preq, input int pidx, input bit uv, input int uidx, input bit ut);
      bit   full;
      bit   accept;
      bit   drain;
      upd_t e;
      pred_req  = preq;
      pred_idx  = IDX_W'(pidx);
      upd_valid = uv;
      upd_idx   = IDX_W'(uidx);
      upd_taken = ut;
      #1;
      full = (m_q.size() == UQ_DEPTH);
      check("pred_ready", pred_ready, !full);
      check("upd_ready",  upd_ready,  !full);
      accept = preq && !full;
      drain  = full || (!preq && m_q.size() > 0);
      if (accept) begin
         m_taken = (m_cnt[pidx] >= 2);
         if (m_spred < 65535) m_spred++;
      end
      m_valid = accept;
      if (preq && full && m_sstall < 65535) m_sstall++;
      if (drain) begin
         e = m_q.pop_front();
         if (e.taken) begin
            if (m_cnt[e.idx] < 3) m_cnt[e.idx]++;
         end else begin
            if (m_cnt[e.idx] > 0) m_cnt[e.idx]--;
         end
      end
      if (uv && !full) begin
         e.idx   = uidx;
         e.taken = ut;
         m_q.push_back(e);
      end
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic idle_inputs();
      pred_req  = 1'b0;
      pred_idx  = '0;
      upd_valid = 1'b0;
      upd_idx   = '0;
      upd_taken = 1'b0;
   endtask

   // Asserts reset between clock edges and checks that it takes effect
   // without waiting for a clock edge. Entered and left at posedge+1.
   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_q_count",    q_count,    0);
      check("rst_pred_valid", pred_valid, 0);
      check("rst_pred_taken", pred_taken, 0);
      check("rst_stat_pred",  stat_pred,  0);
      check("rst_stat_stall", stat_stall, 0);
      model_reset();
      idle_inputs();
      @(posedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic wait_drained(input string tag);
      for (int n = 0; n < 20 && q_count != 0; n++)
         cycle(1'b0, 0, 1'b0, 0, 1'b0);
      check(tag, q_count, 0);
   endtask

   // -------------------------------------------------------------------------
   // Stimulus
   // -------------------------------------------------------------------------
   initial begin
      rst_n = 1'b0;
      idle_inputs();
      model_reset();
      #1;
      check("init_q_count",    q_count,    0);
      check("init_pred_valid", pred_valid, 0);
      check("init_pred_taken", pred_taken, 0);
      check("init_upd_ready",  upd_ready,  1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // A fresh table predicts taken.
      cycle(1'b1, 5, 1'b0, 0, 1'b0);
      check("r031_valid", pred_valid, 1);
      check("r031_taken", pred_taken, 1);
      cycle(1'b0, 0, 1'b0, 0, 1'b0);
      check("r031_valid_drop", pred_valid, 0);
      check("r031_taken_hold", pred_taken, 1);

      // Two not-taken updates move counter 3 from 3 down to 1.
      cycle(1'b0, 0, 1'b1, 3, 1'b0);
      cycle(1'b0, 0, 1'b1, 3, 1'b0);
      wait_drained("r032_drained");
      cycle(1'b1, 3, 1'b0, 0, 1'b0);
      check("r032_taken", pred_taken, 0);

      // Fill the queue behind a steady prediction stream, then force a drain.
      reset_mid();
      for (int i = 0; i < 4; i++)
         cycle(1'b1, i, 1'b1, 8 + i, i[0]);
      check("r033_full",       q_count,    4);
      check("r033_pred_ready", pred_ready, 0);
      check("r033_upd_ready",  upd_ready,  0);
      cycle(1'b1, 2, 1'b1, 5, 1'b1);
      check("r033_drained",     q_count,    3);
      check("r033_pred_ready1", pred_ready, 1);
      check("r033_stall",       stat_stall, STATS ? 1 : 0);
      check("r033_pred_cnt",    stat_pred,  STATS ? 4 : 0);

      // Saturation at both ends.
      reset_mid();
      for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 0, 1'b1);
      wait_drained("r034_drain_up");
      cycle(1'b1, 0, 1'b0, 0, 1'b0);
      check("r034_sat_high", pred_taken, 1);
      for (int i = 0; i < 5; i++) cycle(1'b0, 0, 1'b1, 0, 1'b0);
      wait_drained("r034_drain_down");
      cycle(1'b1, 0, 1'b0, 0, 1'b0);
      check("r034_sat_low", pred_taken, 0);
      // A single taken update moves 0 to 1, which still predicts not-taken.
      cycle(1'b0, 0, 1'b1, 0, 1'b1);
      wait_drained("r034_drain_one");
      cycle(1'b1, 0, 1'b0, 0, 1'b0);
      check("r034_after_one", pred_taken, 0);

      // Reset with updates queued and a prediction in flight.
      cycle(1'b1, 1, 1'b1, 7, 1'b0);
      cycle(1'b1, 2, 1'b1, 7, 1'b0);
      check("r035_q_before",     q_count,    2);
      check("r035_valid_before", pred_valid, 1);
      reset_mid();
      cycle(1'b1, 7, 1'b0, 0, 1'b0);
      check("r035_taken_after", pred_taken, 1);

      // Randomized traffic with repeated indices and one mid-run reset.
      for (int n = 0; n < 1500; n++) begin
         int  pi;
         int  ui;
         bit  pr;
         bit  uv;
         if (n == 700) reset_mid();
         pr = ($urandom_range(0, 99) < 55);
         uv = ($urandom_range(0, 99) < 60);
         pi = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TBL_SIZE - 1));
         ui = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, TBL_SIZE - 1));
         cycle(pr, pi, uv, ui, 1'($urandom_range(0, 1)));
      end

      // Drain whatever is left, then read every counter back.
      wait_drained("final_drain");
      for (int i = 0; i < TBL_SIZE; i++)
         cycle(1'b1, i, 1'b0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pht_scheduler.md
PHT_SCHEDULER -- requirements
Module: pht_scheduler

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning table index width; the table holds 2^IDX_W 2-bit saturating counters.
REQ-002 The block SHALL have parameter UQ_DEPTH, default 4, meaning update-queue depth; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-004 The block SHALL have port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL have port pred_req, input, 1 bit, meaning prediction request.
REQ-007 The block SHALL have port pred_idx, input, IDX_W bits, meaning counter index for the prediction.
REQ-008 The block SHALL have port pred_ready, output, 1 bit, meaning a prediction can be accepted this cycle.
REQ-009 The block SHALL have port pred_valid, output, 1 bit, meaning pred_taken is valid this cycle.
REQ-010 The block SHALL have port pred_taken, output, 1 bit, meaning predicted direction.
REQ-011 The block SHALL have port upd_valid, input, 1 bit, meaning a resolved branch is offered.
REQ-012 The block SHALL have port upd_idx, input, IDX_W bits, meaning counter index to train.
REQ-013 The block SHALL have port upd_taken, input, 1 bit, meaning resolved direction.
REQ-014 The block SHALL have port upd_ready, output, 1 bit, meaning the update queue is not full.
REQ-015 The block SHALL have port q_count, output, clog2(UQ_DEPTH)+1 bits, meaning the number of queued updates.
REQ-016 The block SHALL have ports stat_pred and stat_stall, outputs, 16 bits each, meaning accepted predictions and stalled request cycles.

Function
REQ-017 The block SHALL grant the single table access slot each cycle in this priority: drain the update queue if the queue is full; else serve pred_req; else drain if the queue is non-empty; else idle.
REQ-018 pred_ready SHALL equal (q_count != UQ_DEPTH), combinationally.
REQ-019 A prediction SHALL be accepted when pred_req && pred_ready; on the next cycle pred_valid=1 and pred_taken=bit[1] of counter[pred_idx] as sampled in the acceptance cycle.
REQ-020 pred_valid SHALL be 0 in any cycle that does not follow an accepted prediction; pred_taken SHALL hold its last value when pred_valid=0.
REQ-021 An update SHALL be enqueued when upd_valid && upd_ready, and upd_ready SHALL equal (q_count != UQ_DEPTH).
REQ-022 A drain SHALL pop the queue head and apply it in the same cycle as a read-modify-write: if taken and the counter is below 3, increment; if not taken and the counter is above 0, decrement; otherwise hold.
REQ-023 Updates SHALL be applied in strict FIFO order; repeated updates to one index SHALL be applied cumulatively, one per drain.
REQ-024 A simultaneous enqueue and drain SHALL leave q_count unchanged, and the pointers SHALL wrap modulo UQ_DEPTH.
REQ-025 Queued, not-yet-drained updates SHALL NOT affect predictions; no forwarding is performed.
REQ-026 A predict and a table write SHALL never occur in the same cycle.

Reset
REQ-027 While rst_n=0, all counters SHALL be 2'b11, the queue SHALL be empty (q_count=0), pred_valid=0, pred_taken=0, and stat_pred=stat_stall=0, without waiting for a clock edge.
REQ-028 Reset asserted mid-operation SHALL discard all queued updates and any prediction in flight.

Configuration
REQ-029 With macro PHT_STATS_EN defined, stat_pred SHALL count accepted predictions and stat_stall SHALL count cycles with pred_req && !pred_ready; both SHALL saturate at 16'hFFFF.
REQ-030 Without PHT_STATS_EN, stat_pred and stat_stall SHALL be constant 0 and no counter registers SHALL be built.

Verification
REQ-031 After reset, assert pred_req with pred_idx=5 for one cycle -> the next cycle shows pred_valid=1 and pred_taken=1.
REQ-032 Enqueue two not-taken updates to index 3 with pred_req low, wait until q_count=0, then predict index 3 -> pred_taken=0 (counter=1).
REQ-033 Hold pred_req high and enqueue 4 updates back-to-back -> when q_count=4, pred_ready=0 and upd_ready=0; a drain occurs; pred_ready=1 the following cycle; stat_stall increments by 1 with PHT_STATS_EN.
REQ-034 Saturation: 3 taken updates to index 0 from reset -> counter stays 3; then 4 not-taken -> 0; a 5th not-taken -> stays 0, and a predict returns 0.
REQ-035 Assert rst_n=0 between clock edges with q_count=2 and pred_valid=1 -> q_count=0 and pred_valid=0 immediately; after release, a predict of any index returns 1.
REQ-036 Build without PHT_STATS_EN and rerun REQ-033 -> stat_pred and stat_stall remain 0.
